screen_ram_v2: RTL and testbench
================================

Name: screen_ram_v2

Overview:
- Next-generation CPU data RAM with an embedded, parametrised framebuffer region.
- CPU port: synchronous read/write. Video port: 2-stage pipelined fetch with per-pixel extraction, hardware scroll and out-of-screen blanking.
- Hardware clear engine fills the framebuffer with a constant word.
- Sits between CPU core and VGA controller, both on CPUclk.

Parameters:
- WIDTH, 16, data word width in bits (power of 2).
- REGISTER_COUNT, 2048, total words.
- RAM_SCREEN_OFFSET, 1024, first framebuffer word address.
- BITS_PER_MEMORY_PIXEL_X, 2, log2 of screen pixels per memory pixel, horizontal.
- BITS_PER_MEMORY_PIXEL_Y, 2, log2 of screen pixels per memory pixel, vertical.
- SCREEN_WIDTH_PX, 512, visible width covered by the framebuffer.
- SCREEN_HEIGHT_PX, 480, visible height covered by the framebuffer.
- Derived values:
  - PIXELS_PER_WORD = WIDTH << BPMX.
  - WORDS_PER_LINE = SCREEN_WIDTH_PX / PIXELS_PER_WORD (8).
  - LINES = SCREEN_HEIGHT_PX >> BPMY (120).
  - SCREEN_WORDS = WORDS_PER_LINE * LINES (960).
  - Elaboration error if RAM_SCREEN_OFFSET + SCREEN_WORDS > REGISTER_COUNT.

Ports:
- CPUclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  clog2(REGISTER_COUNT)  CPU word address.
- wdata  in  WIDTH  CPU write data.
- we  in  1  CPU write enable.
- rdata  out  WIDTH  CPU read data.
- pixel_x  in  10  current screen column.
- pixel_y  in  10  current screen row.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- scroll_x  in  clog2(WORDS_PER_LINE)  horizontal scroll, in words.
- scroll_y  in  clog2(LINES)  vertical scroll, in memory lines.
- clear_start  in  1  pulse: start framebuffer clear.
- clear_value  in  WIDTH  fill word.
- clear_busy  out  1  clear engine active.
- pixel_out  out  WIDTH  fetched framebuffer word.
- pixel_on  out  1  selected pixel bit.

Behaviour:
- Reset:
  - rdata, pixel_out, pixel_on, clear_busy, all pipeline registers and latched scroll registers go to 0.
  - Clear FSM goes to IDLE.
  - Memory contents are not reset.
- CPU port, latency 1:
  - we=1: memory[addr] <= wdata and rdata <= wdata (write-first).
  - we=0: rdata <= memory[addr].
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clear_start=1 latches clear_value and ptr=0, then goes to CLEAR. clear_busy=1 from the next cycle.
  - CLEAR, we=0: memory[RAM_SCREEN_OFFSET+ptr] <= latched value, ptr++. rdata holds its previous value that cycle.
  - CLEAR, we=1: the CPU write wins, ptr does not advance (stall), rdata <= wdata.
  - After the write with ptr = SCREEN_WORDS-1, return to IDLE. clear_busy=0 the following cycle.
  - Without stalls, clear_busy is high for exactly SCREEN_WORDS cycles.
  - clear_start while busy is ignored.
  - reset mid-clear aborts to IDLE; already-written words stay written.
- Scroll latch: on frame_start=1, sx <= scroll_x and sy <= scroll_y. Mid-frame changes to scroll_x/scroll_y have no effect.
- Video pipeline, latency 2 cycles from pixel_x/pixel_y to pixel_out/pixel_on:
  - S0 address:
    - line = ((pixel_y >> BPMY) + sy) mod LINES.
    - word = ((pixel_x / PIXELS_PER_WORD) + sx) mod WORDS_PER_LINE.
    - address = RAM_SCREEN_OFFSET + line*WORDS_PER_LINE + word.
    - Registered read.
    - Bit index = WIDTH-1 - ((pixel_x >> BPMX) mod WIDTH), so the MSB is the leftmost pixel. It is delayed alongside the read.
    - An in-range flag (pixel_x < SCREEN_WIDTH_PX and pixel_y < SCREEN_HEIGHT_PX) is delayed alongside the read.
  - S1 select:
    - pixel_out <= word, pixel_on <= word[bit index].
    - If out of range, both are 0.
- The video port only reads. A same-cycle CPU or clear write to the fetched address returns the old data (read-before-write on port B).

Optional Feature:
- Macro SCREEN_RAM_SCROLL_EN.
- Defined: scroll latch and modulo offsets are as above.
- Undefined:
  - scroll_x, scroll_y and frame_start are ignored.
  - sx = sy = 0; no scroll registers are synthesised.
  - Addressing equals the unscrolled mapping.

Test Plan:
- Reset, then write addr 5 = 16'hA5A5 with we=1 → rdata=16'hA5A5 next cycle. Read addr 5 with we=0 → 16'hA5A5 after 1 cycle.
- Write memory[1024]=16'h8001, drive pixel_x=0, pixel_y=0 → 2 cycles later pixel_out=16'h8001, pixel_on=1. pixel_x=4 → pixel_on=0. pixel_x=60 (bit 0) → pixel_on=1.
- pixel_x=520 or pixel_y=480 → pixel_out=0, pixel_on=0.
- Write memory[1024+8*2+1]=16'hFFFF, pulse frame_start with scroll_x=1, scroll_y=2, pixel_x=0, pixel_y=0 → pixel_on=1. Then scroll_x=7 and pixel_x=64 (word 1 → wraps to 0) → fetches line 2 word 0 (SCREEN_RAM_SCROLL_EN defined).
- clear_start with clear_value=16'h1234 → clear_busy high for 960 cycles, then memory[1024..1983]=16'h1234 and memory[1023], memory[1984] unchanged.
- Clear with a CPU write injected at cycle 10 → busy lasts 961 cycles and the CPU word is stored. Separately, assert reset at cycle 100 → busy=0 next cycle and words 1024..1123 are cleared.

Source files
------------

// File: rtl/screen_ram_v2.sv
// CPU data RAM with an embedded framebuffer: 1-cycle CPU port, 2-stage video fetch and clear engine.
// Optional hardware scroll is enabled by defining SCREEN_RAM_SCROLL_EN.
module screen_ram_v2 #(
    parameter int unsigned WIDTH                   = 16,
    parameter int unsigned REGISTER_COUNT          = 2048,
    parameter int unsigned RAM_SCREEN_OFFSET       = 1024,
    parameter int unsigned BITS_PER_MEMORY_PIXEL_X = 2,
    parameter int unsigned BITS_PER_MEMORY_PIXEL_Y = 2,
    parameter int unsigned SCREEN_WIDTH_PX         = 512,
    parameter int unsigned SCREEN_HEIGHT_PX        = 480,
    localparam int unsigned PIXELS_PER_WORD = WIDTH << BITS_PER_MEMORY_PIXEL_X,
    localparam int unsigned WORDS_PER_LINE  = SCREEN_WIDTH_PX / PIXELS_PER_WORD,
    localparam int unsigned LINES           = SCREEN_HEIGHT_PX >> BITS_PER_MEMORY_PIXEL_Y,
    localparam int unsigned SCREEN_WORDS    = WORDS_PER_LINE * LINES,
    localparam int unsigned AW              = $clog2(REGISTER_COUNT),
    localparam int unsigned SXW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1,
    localparam int unsigned SYW = (LINES > 1) ? $clog2(LINES) : 1
) (
    input  logic             CPUclk,
    input  logic             reset,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             we,
    output logic [WIDTH-1:0] rdata,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic             frame_start,
    input  logic [SXW-1:0]   scroll_x,
    input  logic [SYW-1:0]   scroll_y,
    input  logic             clear_start,
    input  logic [WIDTH-1:0] clear_value,
    output logic             clear_busy,
    output logic [WIDTH-1:0] pixel_out,
    output logic             pixel_on
);

    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned PW = (SCREEN_WORDS > 1) ? $clog2(SCREEN_WORDS) : 1;

    if (RAM_SCREEN_OFFSET + SCREEN_WORDS > REGISTER_COUNT) begin : g_bad_geometry
        $error("screen_ram_v2: framebuffer does not fit inside the RAM");
    end

    typedef enum logic [0:0] {StIdle, StClear} clr_state_e;

    logic [WIDTH-1:0] mem [REGISTER_COUNT];

    clr_state_e       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] clr_val_q, clr_val_d;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;

    logic [SXW-1:0]   sx;
    logic [SYW-1:0]   sy;

    logic [31:0]      line_idx, word_idx;
    logic [AW-1:0]    vid_addr;
    logic [BW-1:0]    bit_d;
    logic             in_range_d;

    logic [WIDTH-1:0] vid_word_q;
    logic [BW-1:0]    vid_bit_q;
    logic             vid_in_q;

    // Clear engine: one framebuffer word per cycle, stalled by any CPU write.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        clr_val_d = clr_val_q;
        clr_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clear_start) begin
                    state_d   = StClear;
                    ptr_d     = '0;
                    clr_val_d = clear_value;
                end
            end
            StClear: begin
                if (!we) begin
                    clr_we = 1'b1;
                    if (ptr_q == PW'(SCREEN_WORDS - 1)) begin
                        state_d = StIdle;
                    end else begin
                        ptr_d = ptr_q + PW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CPUclk) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            clr_val_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            clr_val_q <= clr_val_d;
        end
    end

    assign clear_busy = (state_q == StClear);
    assign clr_addr   = AW'(RAM_SCREEN_OFFSET + 32'(ptr_q));

    always_ff @(posedge CPUclk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (clr_we && !reset) begin
            mem[clr_addr] <= clr_val_q;
        end
    end

    // rdata holds while the clear engine owns the write port.
    always_ff @(posedge CPUclk) begin
        if (reset) begin
            rdata <= '0;
        end else if (we) begin
            rdata <= wdata;
        end else if (state_q != StClear) begin
            rdata <= mem[addr];
        end
    end

`ifdef SCREEN_RAM_SCROLL_EN
    logic [SXW-1:0] sx_q;
    logic [SYW-1:0] sy_q;

    always_ff @(posedge CPUclk) begin
        if (reset) begin
            sx_q <= '0;
            sy_q <= '0;
        end else if (frame_start) begin
            sx_q <= scroll_x;
            sy_q <= scroll_y;
        end
    end

    assign sx = sx_q;
    assign sy = sy_q;
`else
    logic unused_scroll;
    assign unused_scroll = ^{frame_start, scroll_x, scroll_y};
    assign sx = '0;
    assign sy = '0;
`endif

    always_comb begin
        line_idx   = ((32'(pixel_y) >> BITS_PER_MEMORY_PIXEL_Y) + 32'(sy)) % LINES;
        word_idx   = ((32'(pixel_x) / PIXELS_PER_WORD) + 32'(sx)) % WORDS_PER_LINE;
        vid_addr   = AW'(RAM_SCREEN_OFFSET + line_idx * WORDS_PER_LINE + word_idx);
        // MSB is the leftmost pixel; WIDTH is a power of two so inversion is WIDTH-1-i.
        bit_d      = BW'(~(pixel_x >> BITS_PER_MEMORY_PIXEL_X));
        in_range_d = (32'(pixel_x) < SCREEN_WIDTH_PX) && (32'(pixel_y) < SCREEN_HEIGHT_PX);
    end

    always_ff @(posedge CPUclk) begin
        if (reset) begin
            vid_word_q <= '0;
            vid_bit_q  <= '0;
            vid_in_q   <= 1'b0;
            pixel_out  <= '0;
            pixel_on   <= 1'b0;
        end else begin
            vid_word_q <= mem[vid_addr];
            vid_bit_q  <= bit_d;
            vid_in_q   <= in_range_d;
            pixel_out  <= vid_in_q ? vid_word_q : '0;
            pixel_on   <= vid_in_q ? vid_word_q[vid_bit_q] : 1'b0;
        end
    end

endmodule

// File: tb/tb_screen_ram_v2.sv
// Randomized bench for screen_ram_v2 against a word-array reference model of the RAM,
// clear engine and scrolled framebuffer lookup.
module tb_screen_ram_v2;

    logic        CPUclk = 1'b0;
    logic        reset;
    logic [10:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] rdata;
    logic [9:0]  pixel_x, pixel_y;
    logic        frame_start;
    logic [2:0]  scroll_x;
    logic [6:0]  scroll_y;
    logic        clear_start;
    logic [15:0] clear_value;
    logic        clear_busy;
    logic [15:0] pixel_out;
    logic        pixel_on;

    screen_ram_v2 dut (
        .CPUclk      (CPUclk),
        .reset       (reset),
        .addr        (addr),
        .wdata       (wdata),
        .we          (we),
        .rdata       (rdata),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start),
        .scroll_x    (scroll_x),
        .scroll_y    (scroll_y),
        .clear_start (clear_start),
        .clear_value (clear_value),
        .clear_busy  (clear_busy),
        .pixel_out   (pixel_out),
        .pixel_on    (pixel_on)
    );

    always #5 CPUclk = ~CPUclk;

    // Reference model state
    logic [15:0] m [2048];
    logic [15:0] m_rd;
    logic        m_busy;
    int          m_ptr;
    logic [15:0] m_cval;
    int          m_sx, m_sy;
    logic [16:0] st1, expv;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Framebuffer lookup straight from the screen geometry: 64 px per word, 8 words per line,
    // 4 screen rows per memory line, 120 memory lines.
    function automatic logic [16:0] vid(input int px, input int py);
        int line, word;
        logic [15:0] w;
        if (px >= 512 || py >= 480) return 17'h0;
        line = ((py / 4) + m_sy) % 120;
        word = ((px / 64) + m_sx) % 8;
        w = m[1024 + line * 8 + word];
        return {w[15 - ((px / 4) % 16)], w};
    endfunction

    task automatic model_step();
        logic [16:0] nv;
        logic        was_busy;
        if (reset) begin
            m_rd = 0; m_busy = 0; m_ptr = 0; st1 = 0; expv = 0; m_sx = 0; m_sy = 0;
            m_cval = 0;
        end else begin
            nv = vid(int'(pixel_x), int'(pixel_y));
            expv = st1;
            st1 = nv;
`ifdef SCREEN_RAM_SCROLL_EN
            if (frame_start) begin
                m_sx = int'(scroll_x);
                m_sy = int'(scroll_y);
            end
`endif
            was_busy = m_busy;
            if (we) begin
                m[addr] = wdata;
                m_rd = wdata;
            end else if (m_busy) begin
                m[1024 + m_ptr] = m_cval;
                m_ptr++;
                if (m_ptr == 960) m_busy = 0;
            end else begin
                m_rd = m[addr];
            end
            if (!was_busy && clear_start) begin
                m_busy = 1; m_ptr = 0; m_cval = clear_value;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CPUclk);
        #1;
        check("rdata", 32'(rdata), 32'(m_rd));
        check("clear_busy", 32'(clear_busy), 32'(m_busy));
        check("pixel_out", 32'(pixel_out), 32'(expv[15:0]));
        check("pixel_on", 32'(pixel_on), 32'(expv[16]));
    endtask

    task automatic idle();
        we = 0; clear_start = 0; frame_start = 0; reset = 0;
    endtask

    task automatic cpu_write(input int a, input logic [15:0] d);
        addr = 11'(a); wdata = d; we = 1;
        tick();
        we = 0;
    endtask

    task automatic cpu_read(input string tag, input int a, input logic [15:0] exp);
        addr = 11'(a); we = 0;
        tick();
        check(tag, 32'(rdata), 32'(exp));
    endtask

    task automatic pixel_check(input string tag, input int px, input int py,
                               input logic [15:0] eword, input logic eon);
        pixel_x = 10'(px); pixel_y = 10'(py);
        tick();
        tick();
        check({tag, "_word"}, 32'(pixel_out), 32'(eword));
        check({tag, "_on"}, 32'(pixel_on), 32'(eon));
    endtask

    // Runs one clear; optionally injects a CPU write or a reset at a given busy cycle.
    task automatic run_clear(input logic [15:0] val, input int inject_at, input int inj_addr,
                             input logic [15:0] inj_data, input int reset_at, output int cycles);
        clear_value = val; clear_start = 1;
        tick();
        clear_start = 0;
        cycles = 0;
        while (clear_busy && cycles < 2000) begin
            we = 0;
            addr = 11'($urandom_range(0, 2047));
            if (cycles == inject_at) begin
                we = 1; addr = 11'(inj_addr); wdata = inj_data;
            end
            if (cycles == reset_at) reset = 1;
            tick();
            reset = 0; we = 0;
            cycles++;
        end
    endtask

    int cyc;
    logic [15:0] fb_expect;

    initial begin
        reset = 1; we = 0; addr = 0; wdata = 0; pixel_x = 0; pixel_y = 0;
        frame_start = 0; scroll_x = 0; scroll_y = 0; clear_start = 0; clear_value = 0;
        for (int i = 0; i < 2048; i++) m[i] = 16'h0;
        m_rd = 0; m_busy = 0; m_ptr = 0; st1 = 0; expv = 0; m_sx = 0; m_sy = 0; m_cval = 0;

        tick();
        tick();
        check("reset_rdata", 32'(rdata), 32'h0);
        check("reset_busy", 32'(clear_busy), 32'h0);
        check("reset_pixel", 32'({pixel_on, pixel_out}), 32'h0);
        idle();

        for (int i = 0; i < 2048; i++) cpu_write(i, 16'($urandom));

        // CPU port basics
        cpu_write(5, 16'hA5A5);
        check("write_first", 32'(rdata), 32'hA5A5);
        cpu_read("read_back5", 5, 16'hA5A5);

        // Pixel extraction and blanking
        cpu_write(1024, 16'h8001);
        pixel_check("px0", 0, 0, 16'h8001, 1'b1);
        pixel_check("px4", 4, 0, 16'h8001, 1'b0);
        pixel_check("px60", 60, 0, 16'h8001, 1'b1);
        pixel_check("px520", 520, 0, 16'h0, 1'b0);
        pixel_check("py480", 0, 480, 16'h0, 1'b0);

        // Scroll
        cpu_write(1024 + 8 * 2 + 1, 16'hFFFF);
        scroll_x = 3'd1; scroll_y = 7'd2; frame_start = 1;
        tick();
        frame_start = 0;
`ifdef SCREEN_RAM_SCROLL_EN
        pixel_check("scroll", 0, 0, 16'hFFFF, 1'b1);
`else
        pixel_check("noscroll", 0, 0, 16'h8001, 1'b1);
`endif
        scroll_x = 3'd7;
        pixel_x = 10'd64; tick(); tick();
        frame_start = 1;
        tick();
        frame_start = 0;
        pixel_x = 10'd64; pixel_y = 10'd0; tick(); tick();

        // Plain clear
        cpu_write(1023, 16'h1111);
        cpu_write(1984, 16'h2222);
        run_clear(16'h1234, -1, 0, 16'h0, -1, cyc);
        check("clear_cycles", 32'(cyc), 32'd960);
        cpu_read("clear_first", 1024, 16'h1234);
        cpu_read("clear_last", 1983, 16'h1234);
        cpu_read("below_fb", 1023, 16'h1111);
        cpu_read("above_fb", 1984, 16'h2222);

        // Clear with one stalling CPU write into an already-cleared word
        run_clear(16'h0F0F, 10, 1029, 16'hBEEF, -1, cyc);
        check("stall_cycles", 32'(cyc), 32'd961);
        cpu_read("stall_word", 1029, 16'hBEEF);
        cpu_read("stall_next", 1030, 16'h0F0F);

        // Reset part way through a clear
        run_clear(16'hC3C3, -1, 0, 16'h0, 100, cyc);
        check("abort_cycles", 32'(cyc), 32'd101);
        check("abort_busy", 32'(clear_busy), 32'h0);
        cpu_read("abort_last", 1123, 16'hC3C3);
        cpu_read("abort_kept", 1124, 16'h0F0F);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            we = ($urandom_range(0, 7) == 0);
            addr = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(1024, 1983))
                                              : 11'($urandom);
            wdata = 16'($urandom);
            pixel_x = 10'($urandom_range(0, 639));
            pixel_y = 10'($urandom_range(0, 524));
            frame_start = ($urandom_range(0, 49) == 0);
            scroll_x = 3'($urandom);
            scroll_y = 7'($urandom);
            clear_start = ($urandom_range(0, 399) == 0);
            clear_value = 16'($urandom);
            reset = 0;
            if ($urandom_range(0, 999) == 0) begin
                reset = 1; we = 0;
            end
            tick();
        end
        idle();
        for (int i = 0; i < 1100 && clear_busy; i++) tick();
        check("final_idle", 32'(clear_busy), 32'h0);
        for (int i = 1024; i < 1040; i++) begin
            fb_expect = m[i];
            cpu_read("final_fb", i, fb_expect);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
